// File: rtl/instr_feeder_pkg.sv
// instr_feeder_pkg: shared types and defaults for the instruction feeder.
//   feeder_state_t  - sequencer state encoding
//   DEFAULT_TIMEOUT - default wait-state cycle budget
//   is_running()    - true for states in which the feeder reports busy
package instr_feeder_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_ACK,
    ST_EXEC,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } feeder_state_t;

  // Busy covers every state between an accepted start and the return to idle.
  function automatic logic is_running(input feeder_state_t st);
    return !((st == ST_IDLE) || (st == ST_ERR));
  endfunction

endpackage

// File: rtl/instr_feeder_buffer.sv
// prog_buffer: SIZE x WIDTH program store.
//   clk, reset    - clock, async active-high reset (clears every entry)
//   we/waddr/wdata - synchronous write port
//   raddr/rdata_c  - combinational read port
module prog_buffer #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata_c
);

  logic [WIDTH-1:0] mem [SIZE];

  // Storage array with write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: host-side sequencer driving the CPU instruction interface.
// Loads each buffered instruction into the CPU, strobes start, waits for the
// CPU wait flag to drop and return, captures the result, and repeats.
//   clk, reset                     - clock, async active-high reset
//   prog_we/prog_addr/prog_data    - program buffer write (idle only)
//   prog_len, start                - run request (idle or error only)
//   busy, done, error, pc          - run status
//   instruction_in, load_instr, s  - CPU instruction handshake outputs
//   w, cpu_out                     - CPU wait flag and datapath result
//   result, result_valid           - captured CPU result
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [WIDTH-1:0]      prog_data,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [WIDTH-1:0]      instruction_in,
  output logic                  load_instr,
  output logic                  s,
  input  logic                  w,
  input  logic [WIDTH-1:0]      cpu_out,
  output logic [WIDTH-1:0]      result,
  output logic                  result_valid
);

  localparam int unsigned LEN_WIDTH   = ADDR_WIDTH + 1;
  localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT + 1);

  feeder_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;

  logic                   busy_d, done_d, error_d, load_instr_d, s_d, result_valid_d;
  logic [WIDTH-1:0]       instr_d, result_d;

  logic                   buf_we_c;
  logic                   start_ok_c;
  logic [LEN_WIDTH-1:0]   len_clamped_c;
  logic [LEN_WIDTH-1:0]   pc_inc_c;
  logic [TIMER_WIDTH-1:0] timer_inc_c;
  logic                   timeout_c;
  logic [WIDTH-1:0]       rd_word_c;
  logic [WIDTH-1:0]       load_word_c;

  assign buf_we_c      = prog_we && (state_q == ST_IDLE);
  assign start_ok_c    = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));
  assign len_clamped_c = (prog_len > LEN_WIDTH'(SIZE)) ? LEN_WIDTH'(SIZE) : prog_len;
  assign pc_inc_c      = {1'b0, pc} + LEN_WIDTH'(1);
  assign timer_inc_c   = (timer_q == TIMER_WIDTH'(TIMEOUT)) ? timer_q
                                                            : timer_q + TIMER_WIDTH'(1);
  assign timeout_c     = (timer_inc_c == TIMER_WIDTH'(TIMEOUT));

  prog_buffer #(
    .SIZE      (SIZE),
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .we     (buf_we_c),
    .waddr  (prog_addr),
    .wdata  (prog_data),
    .raddr  (pc_d),
    .rdata_c(rd_word_c)
  );

  // A write landing on the same edge as the load must be seen by that load.
  assign load_word_c = (buf_we_c && (prog_addr == pc_d)) ? prog_data : rd_word_c;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pc             <= '0;
      len_q          <= '0;
      timer_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      load_instr     <= 1'b0;
      s              <= 1'b0;
      result_valid   <= 1'b0;
      instruction_in <= '0;
      result         <= '0;
    end else begin
      state_q        <= state_d;
      pc             <= pc_d;
      len_q          <= len_d;
      timer_q        <= timer_d;
      busy           <= busy_d;
      done           <= done_d;
      error          <= error_d;
      load_instr     <= load_instr_d;
      s              <= s_d;
      result_valid   <= result_valid_d;
      instruction_in <= instr_d;
      result         <= result_d;
    end
  end

  // Next-state, program counter, length latch and wait timer
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    len_d   = len_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start_ok_c) begin
          len_d   = len_clamped_c;
          pc_d    = '0;
          timer_d = '0;
          state_d = (len_clamped_c == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_START;
      ST_START: begin
        timer_d = '0;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!w) begin
          timer_d = '0;
          state_d = ST_EXEC;
        end else if (timeout_c) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_inc_c;
        end
      end
      ST_EXEC: begin
        if (w) begin
          state_d = ST_NEXT;
        end else if (timeout_c) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_inc_c;
        end
      end
      ST_NEXT: begin
        if (pc_inc_c == len_q) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc + ADDR_WIDTH'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, aligned with the state being entered
  always_comb begin
    busy_d         = is_running(state_d);
    done_d         = (state_d == ST_DONE);
    error_d        = (state_d == ST_ERR);
    load_instr_d   = (state_d == ST_LOAD);
    s_d            = (state_d == ST_START);
    result_valid_d = (state_q == ST_EXEC) && w;
    instr_d        = instruction_in;
    result_d       = result;
    if (state_d == ST_LOAD) begin
      instr_d = load_word_c;
    end
    if (result_valid_d) begin
      result_d = cpu_out;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;

  localparam int unsigned SIZE      = 8;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned AW        = 3;
  localparam int          RUN_BOUND = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [WIDTH-1:0] prog_data;
  logic [AW:0]      prog_len;
  logic             start;
  logic             busy, done, error;
  logic [AW-1:0]    pc;
  logic [WIDTH-1:0] instruction_in;
  logic             load_instr, s;
  logic             w;
  logic [WIDTH-1:0] cpu_out;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  instr_feeder #(
    .SIZE   (SIZE),
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .prog_len      (prog_len),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .pc            (pc),
    .instruction_in(instruction_in),
    .load_instr    (load_instr),
    .s             (s),
    .w             (w),
    .cpu_out       (cpu_out),
    .result        (result),
    .result_valid  (result_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference program image and per-instruction CPU latencies (indexed by global load count)
  logic [WIDTH-1:0] buf_m [SIZE];
  int               d_arr [256];
  int               e_arr [256];

  // Recorder / CPU stand-in state
  logic [WIDTH-1:0] load_q [$];
  logic [WIDTH-1:0] res_q  [$];
  int               done_cnt = 0;
  int               s_cnt    = 0;
  logic             hang_ack, hang_exec, pc3_mode, cpu_rst;
  int               pc3_base;

  function automatic logic [WIDTH-1:0] cpu_fn(input logic [WIDTH-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h0F0F;
  endfunction

  // Behavioural CPU: drops w d cycles after s, raises it e cycles later with a result
  initial begin : cpu_model
    int phase;
    int cnt;
    int idx;
    logic [WIDTH-1:0] cur_word;
    phase = 0; cnt = 0; idx = 0; cur_word = '0;
    w = 1'b1;
    cpu_out = '0;
    forever begin
      @(negedge clk);
      if (reset || cpu_rst) begin
        w = 1'b1;
        phase = 0;
      end else begin
        if (load_instr) begin
          cur_word = instruction_in;
          load_q.push_back(instruction_in);
          idx = load_q.size() - 1;
        end
        if (result_valid) res_q.push_back(result);
        if (done) done_cnt++;
        if (s) s_cnt++;
        case (phase)
          0: if (s && !hang_ack) begin
               cnt = d_arr[idx % 256];
               phase = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 w = 1'b0;
                 cnt = e_arr[idx % 256];
                 phase = 2;
               end
             end
          2: if (!hang_exec) begin
               cnt--;
               if (cnt == 0) begin
                 w = 1'b1;
                 cpu_out = pc3_mode ? WIDTH'(3 * (idx - pc3_base)) : cpu_fn(cur_word);
                 phase = 0;
               end
             end
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    buf_m[a] = d;
  endtask

  task automatic set_delays(input int base, input int n, input int dfix, input int efix);
    for (int i = 0; i < n; i++) begin
      d_arr[(base + i) % 256] = (dfix > 0) ? dfix : int'($urandom_range(1, 4));
      e_arr[(base + i) % 256] = (efix > 0) ? efix : int'($urandom_range(1, 5));
    end
  endtask

  // Issue start and follow the run until done/error or the cycle budget expires
  task automatic run(input int len, input logic busy_wr,
                     output int cyc, output logic l1, output logic s2, output logic e1);
    prog_len = (AW + 1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    prog_we = 1'b0;
    cyc = 1; l1 = load_instr; e1 = error; s2 = 1'b0;
    while (!done && !error && cyc < RUN_BOUND) begin
      tick();
      cyc++;
      if (cyc == 2) begin
        s2 = s;
        if (busy_wr) begin
          prog_we = 1'b1; prog_addr = '0; prog_data = 16'hFFFF;
        end
      end
      if (cyc == 3) prog_we = 1'b0;
    end
  endtask

  task automatic run_and_check(input string tag, input int len, input int dfix,
                               input logic busy_wr, input logic wr_start,
                               input logic [WIDTH-1:0] wr_data);
    int n, cyc, exp_cyc, base, rbase, sbase, dbase;
    logic l1, s2, e1;
    logic [WIDTH-1:0] exp_res;
    n = (len > int'(SIZE)) ? int'(SIZE) : len;
    base = load_q.size(); rbase = res_q.size(); sbase = s_cnt; dbase = done_cnt;
    pc3_base = base;
    set_delays(base, n, dfix, 0);
    if (wr_start) begin
      prog_we = 1'b1; prog_addr = '0; prog_data = wr_data;
      buf_m[0] = wr_data;
    end
    run(len, busy_wr, cyc, l1, s2, e1);
    tick(); tick();
    exp_cyc = 1;
    for (int i = 0; i < n; i++) exp_cyc += 3 + d_arr[(base + i) % 256] + e_arr[(base + i) % 256];
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_err_cleared"}, 32'(e1), 32'(0));
    if (n > 0) begin
      chk({tag, "_load_first"}, 32'(l1), 32'(1));
      chk({tag, "_s_second"}, 32'(s2), 32'(1));
    end
    chk({tag, "_nloads"}, 32'(load_q.size() - base), 32'(n));
    chk({tag, "_nres"}, 32'(res_q.size() - rbase), 32'(n));
    chk({tag, "_ns"}, 32'(s_cnt - sbase), 32'(n));
    chk({tag, "_ndone"}, 32'(done_cnt - dbase), 32'(1));
    for (int i = 0; i < n && (base + i) < load_q.size(); i++)
      chk({tag, "_word"}, 32'(load_q[base + i]), 32'(buf_m[i]));
    for (int i = 0; i < n && (rbase + i) < res_q.size(); i++) begin
      exp_res = pc3_mode ? WIDTH'(3 * i) : cpu_fn(buf_m[i]);
      chk({tag, "_result"}, 32'(res_q[rbase + i]), 32'(exp_res));
    end
    chk({tag, "_busy_after"}, 32'(busy), 32'(0));
  endtask

  initial begin : main
    int cyc, base;
    logic l1, s2, e1;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; hang_ack = 1'b0; hang_exec = 1'b0; pc3_mode = 1'b0; cpu_rst = 1'b0;
    pc3_base = 0;
    for (int i = 0; i < int'(SIZE); i++) buf_m[i] = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_flags", 32'({busy, done, error, load_instr, s, result_valid}), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_instr", 32'(instruction_in), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    reset = 1'b0;
    tick();

    // Two-instruction program, CPU leaves wait two cycles after s
    prog(0, 16'hD105);
    prog(1, 16'hD203);
    run_and_check("basic", 2, 2, 1'b0, 1'b0, '0);

    // Empty program: done straight away, no CPU traffic
    run_and_check("len0", 0, 0, 1'b0, 1'b0, '0);

    // CPU never leaves wait: timeout in ACK, then restart clears error
    hang_ack = 1'b1;
    run(1, 1'b0, cyc, l1, s2, e1);
    chk("ack_to_cycles", 32'(cyc), 32'(3 + TIMEOUT));
    chk("ack_to_error", 32'(error), 32'(1));
    chk("ack_to_busy", 32'(busy), 32'(0));
    hang_ack = 1'b0;
    tick();
    run_and_check("after_ack_to", 1, 0, 1'b0, 1'b0, '0);

    // CPU never finishes: timeout in EXEC
    base = load_q.size();
    set_delays(base, 1, 3, 1);
    hang_exec = 1'b1;
    run(1, 1'b0, cyc, l1, s2, e1);
    chk("exec_to_cycles", 32'(cyc), 32'(3 + 3 + TIMEOUT));
    chk("exec_to_error", 32'(error), 32'(1));
    hang_exec = 1'b0; cpu_rst = 1'b1;
    tick(); tick();
    cpu_rst = 1'b0;
    run_and_check("after_exec_to", 1, 0, 1'b0, 1'b0, '0);

    // Writes while busy are dropped; a write with start is used at once
    prog(0, 16'h3C5A);
    run_and_check("busy_wr", 2, 0, 1'b1, 1'b0, '0);
    run_and_check("busy_wr_rerun", 1, 0, 1'b0, 1'b0, '0);
    run_and_check("wr_with_start", 1, 0, 1'b0, 1'b1, 16'h7E81);

    // Reset while the second instruction executes
    prog(0, 16'h1234); prog(1, 16'h5678); prog(2, 16'h9ABC);
    base = load_q.size();
    set_delays(base, 3, 2, 5);
    prog_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (load_q.size() == base + 2 && w == 1'b0) break;
      tick();
    end
    tick();
    chk("pre_rst_pc", 32'(pc), 32'(1));
    chk("pre_rst_busy", 32'(busy), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_pc", 32'(pc), 32'(0));
    chk("mid_rst_strobes", 32'({s, load_instr, result_valid}), 32'(0));
    chk("mid_rst_result", 32'(result), 32'(0));
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < int'(SIZE); i++) buf_m[i] = '0;
    tick();
    run_and_check("buf_cleared", 1, 0, 1'b0, 1'b0, '0);

    // Full-depth program with cpu_out = 3 * instruction index, then clamped length
    for (int i = 0; i < int'(SIZE); i++) prog(AW'(i), WIDTH'($urandom));
    pc3_mode = 1'b1;
    run_and_check("full", int'(SIZE), 0, 1'b0, 1'b0, '0);
    chk("full_last_result", 32'(result), 32'(21));
    chk("full_pc", 32'(pc), 32'(SIZE - 1));
    run_and_check("clamp", 12, 0, 1'b0, 1'b0, '0);
    pc3_mode = 1'b0;

    // Randomised programs and lengths
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) prog(AW'($urandom_range(0, SIZE - 1)), WIDTH'($urandom));
      run_and_check("rand", int'($urandom_range(1, SIZE)), 0, 1'b0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
